// File: rtl/syn_gpu_fb_fetch.sv
// Frame-buffer fetch: credit-bounded SRAM reads into a word FIFO, unpacked to 8-bit pixels.
// IDLE: wait for frame_start | FETCH: issue reads | DRAIN: reads done, emptying FIFO | FLUSH: abort, absorb returns
module syn_gpu_fb_fetch #(
  parameter int unsigned FB_BASE_ADDR = 0,
  parameter int unsigned H_PIXELS     = 640,
  parameter int unsigned V_LINES      = 480,
  parameter int unsigned SRAM_ADDR_W  = 18,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                   clk_ir,
  input  logic                   rst_sync,
  input  logic                   fetch_en,
  input  logic                   frame_start,
  input  logic                   stat_clr,
  output logic                   busy,
  output logic                   underflow,
  output logic                   frame_ovr,
  output logic                   sram_rd_req,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic                   sram_rd_ack,
  input  logic                   sram_rd_valid,
  input  logic [15:0]            sram_rd_data,
  output logic                   pxl_valid,
  input  logic                   pxl_ready,
  output logic [7:0]             pxl_data,
  output logic                   pxl_sof,
  output logic                   pxl_eol
);
  localparam int unsigned WORDS = H_PIXELS * V_LINES / 2;
  localparam int unsigned CW    = $clog2(WORDS + 1);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned FW    = AW + 1;
  localparam int unsigned XW    = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int unsigned YW    = (V_LINES > 1) ? $clog2(V_LINES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FLUSH} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_req, w_req_nxt;
  logic [SRAM_ADDR_W-1:0] r_addr;
  logic [CW-1:0]          r_req_cnt, w_req_cnt_nxt;
  logic [FW-1:0]          r_outst, w_outst_nxt;
  logic [FW-1:0]          r_cnt, w_cnt_nxt;
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [15:0]            r_mem [FIFO_DEPTH];
  logic                   r_sel;
  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_y;
  logic                   r_first_done, r_frame_done;
  logic                   r_underflow, r_frame_ovr;
  logic                   w_active, w_ack, w_vld_in, w_push, w_pop, w_xfer;
  logic                   w_start, w_clear, w_hold, w_last_x, w_last_y;

  assign w_ack    = r_req && sram_rd_ack;
  assign w_hold   = r_req && !sram_rd_ack;
  assign w_vld_in = sram_rd_valid && (r_state != S_IDLE) && (r_outst != '0);
  assign w_push   = w_vld_in && w_active;
  assign w_xfer   = pxl_valid && pxl_ready;
  assign w_pop    = w_xfer && r_sel;
  assign w_start  = (r_state == S_IDLE) && frame_start && fetch_en;
  assign w_clear  = w_start || ((r_state == S_FLUSH) && (r_outst == '0));
  assign w_last_x = (r_x == XW'(H_PIXELS - 1));
  assign w_last_y = (r_y == YW'(V_LINES - 1));

  assign w_outst_nxt   = r_outst + FW'(w_ack) - FW'(w_vld_in);
  assign w_cnt_nxt     = r_cnt + FW'(w_push) - FW'(w_pop);
  assign w_req_cnt_nxt = r_req_cnt + CW'(w_ack);

  always_ff @(posedge clk_ir) begin
    if (rst_sync) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (!fetch_en && !w_hold)               w_state_nxt = S_FLUSH;
        else if (r_req_cnt == CW'(WORDS))       w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if ((r_outst == '0) && r_frame_done)    w_state_nxt = S_IDLE;
        else if (!fetch_en)                     w_state_nxt = S_FLUSH;
      end
      S_FLUSH: if (r_outst == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    w_active  = (r_state == S_FETCH) || (r_state == S_DRAIN);
    pxl_valid = w_active && (r_cnt != '0);
    pxl_data  = '0;
    if (pxl_valid) pxl_data = r_sel ? r_mem[r_rd_ptr][15:8] : r_mem[r_rd_ptr][7:0];
    pxl_sof   = pxl_valid && (r_x == '0) && (r_y == '0) && !r_first_done;
    pxl_eol   = pxl_valid && w_last_x;
  end

  // Credit check uses next-cycle occupancy so a new request can follow an ack back to back.
  always_comb begin
    w_req_nxt = 1'b0;
    if (w_hold) w_req_nxt = 1'b1;
    else if ((r_state == S_FETCH) && (w_state_nxt == S_FETCH) && fetch_en &&
             (({1'b0, w_cnt_nxt} + {1'b0, w_outst_nxt}) < (FW + 1)'(FIFO_DEPTH)) &&
             (w_req_cnt_nxt < CW'(WORDS)))
      w_req_nxt = 1'b1;
  end

  assign sram_rd_req = r_req;
  assign sram_addr   = r_addr;
  assign underflow   = r_underflow;
  assign frame_ovr   = r_frame_ovr;

  always_ff @(posedge clk_ir) begin
    if (w_push) r_mem[r_wr_ptr] <= sram_rd_data;
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_req_cnt    <= '0;
      r_outst      <= '0;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_sel        <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_first_done <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_frame_ovr  <= 1'b0;
    end else begin
      r_req   <= w_req_nxt;
      r_outst <= w_outst_nxt;
      if (w_start)    r_addr <= SRAM_ADDR_W'(FB_BASE_ADDR);
      else if (w_ack) r_addr <= r_addr + 1'b1;
      r_req_cnt <= w_start ? '0 : w_req_cnt_nxt;
      if (w_clear) begin
        r_cnt    <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_sel    <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_xfer) r_sel    <= ~r_sel;
      end
      if (w_start) begin
        r_x          <= '0;
        r_y          <= '0;
        r_first_done <= 1'b0;
        r_frame_done <= 1'b0;
      end else if (w_xfer) begin
        r_first_done <= 1'b1;
        if (w_last_x) begin
          r_x <= '0;
          if (w_last_y) begin
            r_y          <= '0;
            r_frame_done <= 1'b1;
          end else begin
            r_y <= r_y + 1'b1;
          end
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      // Empty FIFO before the first pixel is the startup fill, not an underflow.
      if (w_active && pxl_ready && !pxl_valid && r_first_done && !r_frame_done)
        r_underflow <= 1'b1;
      else if (stat_clr)
        r_underflow <= 1'b0;
      if (frame_start && (r_state != S_IDLE)) r_frame_ovr <= 1'b1;
      else if (stat_clr)                      r_frame_ovr <= 1'b0;
    end
  end
endmodule
